// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with next-PC select and circular return-address stack
module pc_sequencer #(
  parameter int WIDTH        = 16,
  parameter int INC          = 1,
  parameter int RESET_VECTOR = 0,
  parameter int RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             first,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] ret_addr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RV_W    = WIDTH'(RESET_VECTOR);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [CW-1:0]    count;

  assign PC_plus   = PC + INC_W;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_MAX);

  // top points at the most recent entry; the pointer wraps naturally because RAS_DEPTH is a power of 2
  always_ff @(posedge CLK) begin
    if (first) begin
      PC      <= RV_W;
      top     <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (branch_taken) begin
      PC <= branch_target;
    end else if (!stall) begin
      if (ret) begin
        if (!ras_empty) begin
          PC    <= stack[top];
          top   <= top - PTR_ONE;
          count <= count - CNT_ONE;
        end else begin
          PC      <= PC_plus;
          ras_unf <= 1'b1;
        end
      end else if (call) begin
        PC                  <= jump_target;
        stack[top + PTR_ONE] <= ret_addr;
        top                 <= top + PTR_ONE;
        // a full stack overwrites its oldest entry, so count stays saturated
        if (ras_full) ras_ovf <= 1'b1;
        else          count   <= count + CNT_ONE;
      end else if (jump) begin
        PC <= jump_target;
      end else begin
        PC <= PC_plus;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a queue-based stack model
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        first, stall, branch_taken, jump, call, ret;
  logic [15:0] branch_target, jump_target, ret_addr;
  logic [15:0] PC, PC_plus;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_ovf, m_unf;

  pc_sequencer #(.WIDTH(16), .INC(1), .RESET_VECTOR(0), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .first(first), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .ret_addr(ret_addr), .PC(PC), .PC_plus(PC_plus),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 CLK = ~CLK;

  // drive one cycle of inputs, advance the model by the priority rules, sample 1 time unit after the edge
  task automatic step(input logic f, input logic s, input logic bt, input logic [15:0] btg,
                      input logic j, input logic c, input logic r,
                      input logic [15:0] jt, input logic [15:0] ra);
    first = f; stall = s; branch_taken = bt; branch_target = btg;
    jump = j; call = c; ret = r; jump_target = jt; ret_addr = ra;
    @(posedge CLK);
    if (f) begin
      m_pc = 16'h0000; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (bt) begin
      m_pc = btg;
    end else if (s) begin
      m_pc = m_pc;
    end else if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = m_pc + 16'd1; m_unf = 1'b1; end
    end else if (c) begin
      m_pc = jt;
      if (m_q.size() == DEPTH) begin void'(m_q.pop_front()); m_ovf = 1'b1; end
      m_q.push_back(ra);
    end else if (j) begin
      m_pc = jt;
    end else begin
      m_pc = m_pc + 16'd1;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 16'h1234, 1, 1, 1, 16'h5678, 16'h9abc);
    checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", PC); end
    checks++; if (PC_plus !== 16'h0001) begin errors++; $display("FAIL reset_pc_plus got=%h exp=0001", PC_plus); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras empty=%b full=%b exp 1 0", ras_empty, ras_full); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL reset_flags ovf=%b unf=%b exp 0 0", ras_ovf, ras_unf); end
    for (int i = 1; i <= 3; i++) begin
      idle();
      checks++; if (PC !== 16'(i)) begin errors++; $display("FAIL seq_pc got=%h exp=%h", PC, 16'(i)); end
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 16'h0, 1, 0, 0, 16'hFFFF, 16'h0);
    checks++; if (PC !== 16'hFFFF || PC_plus !== 16'h0000) begin errors++; $display("FAIL wrap_preload pc=%h plus=%h exp ffff 0000", PC, PC_plus); end
    idle();
    checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", PC); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL wrap_flags ovf=%b unf=%b exp 0 0", ras_ovf, ras_unf); end
  endtask

  task automatic test_stall();
    logic [15:0] held;
    held = PC;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 16'h0, 1, 0, 0, 16'h0777, 16'h0);
      checks++; if (PC !== held) begin errors++; $display("FAIL stall_jump_pc got=%h exp=%h", PC, held); end
    end
    step(0, 1, 0, 16'h0, 0, 1, 0, 16'h0888, 16'h0033);
    checks++; if (PC !== held || ras_empty !== 1'b1) begin errors++; $display("FAIL stall_call pc=%h empty=%b exp %h 1", PC, ras_empty, held); end
    step(0, 1, 1, 16'h0040, 1, 0, 0, 16'h0777, 16'h0);
    checks++; if (PC !== 16'h0040) begin errors++; $display("FAIL stall_branch_pc got=%h exp=0040", PC); end
  endtask

  task automatic test_branch_priority();
    step(0, 0, 1, 16'h0100, 0, 1, 0, 16'h0999, 16'h0011);
    checks++; if (PC !== 16'h0100) begin errors++; $display("FAIL branch_call_pc got=%h exp=0100", PC); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL branch_call_ras empty=%b exp=1", ras_empty); end
    step(0, 0, 0, 16'h0, 1, 1, 0, 16'h0500, 16'h0077);
    checks++; if (PC !== 16'h0500 || ras_empty !== 1'b0) begin errors++; $display("FAIL call_over_jump pc=%h empty=%b exp 0500 0", PC, ras_empty); end
    step(0, 0, 0, 16'h0, 1, 0, 1, 16'h0600, 16'h0);
    checks++; if (PC !== 16'h0077 || ras_empty !== 1'b1) begin errors++; $display("FAIL ret_over_jump pc=%h empty=%b exp 0077 1", PC, ras_empty); end
  endtask

  task automatic test_ras_overflow();
    logic [15:0] exp_ret [5];
    exp_ret = '{16'h0014, 16'h0013, 16'h0012, 16'h0011, 16'h0012};
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 16'h0, 0, 1, 0, 16'h0200 + 16'(i), 16'h0010 + 16'(i));
      if (i == 3) begin
        checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0) begin errors++; $display("FAIL ras_fill4 full=%b ovf=%b exp 1 0", ras_full, ras_ovf); end
      end
    end
    checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b1) begin errors++; $display("FAIL ras_ovf full=%b ovf=%b exp 1 1", ras_full, ras_ovf); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0);
      checks++; if (PC !== exp_ret[i]) begin errors++; $display("FAIL ras_ret%0d got=%h exp=%h", i, PC, exp_ret[i]); end
    end
    checks++; if (ras_unf !== 1'b1 || ras_empty !== 1'b1) begin errors++; $display("FAIL ras_unf unf=%b empty=%b exp 1 1", ras_unf, ras_empty); end
  endtask

  task automatic test_call_ret_and_reset();
    step(0, 0, 0, 16'h0, 0, 1, 0, 16'h0300, 16'h0020);
    step(0, 0, 0, 16'h0, 0, 1, 1, 16'h0400, 16'h0055);
    checks++; if (PC !== 16'h0020 || ras_empty !== 1'b1) begin errors++; $display("FAIL call_ret_same pc=%h empty=%b exp 0020 1", PC, ras_empty); end
    step(0, 0, 0, 16'h0, 0, 1, 0, 16'h0700, 16'h0031);
    step(0, 0, 0, 16'h0, 0, 1, 0, 16'h0710, 16'h0032);
    checks++; if (ras_ovf !== 1'b1 || ras_unf !== 1'b1) begin errors++; $display("FAIL sticky_hold ovf=%b unf=%b exp 1 1", ras_ovf, ras_unf); end
    step(1, 0, 0, 16'h0, 0, 1, 0, 16'h0800, 16'h0099);
    checks++; if (PC !== 16'h0000 || ras_empty !== 1'b1) begin errors++; $display("FAIL mid_reset pc=%h empty=%b exp 0000 1", PC, ras_empty); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL mid_reset_flags ovf=%b unf=%b exp 0 0", ras_ovf, ras_unf); end
    step(0, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0);
    checks++; if (PC !== 16'h0001 || ras_unf !== 1'b1) begin errors++; $display("FAIL ret_after_reset pc=%h unf=%b exp 0001 1", PC, ras_unf); end
  endtask

  task automatic test_random();
    int fails_here;
    fails_here = 0;
    step(1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(5) == 0), ($urandom_range(7) == 0), 16'($urandom),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           16'($urandom), 16'($urandom));
      checks++;
      if (PC !== m_pc || PC_plus !== m_pc + 16'd1) begin
        errors++; fails_here++;
        if (fails_here < 10) $display("FAIL rand_pc cyc=%0d pc=%h plus=%h exp=%h", n, PC, PC_plus, m_pc);
      end
      checks++;
      if (ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == DEPTH) ||
          ras_ovf !== m_ovf || ras_unf !== m_unf) begin
        errors++; fails_here++;
        if (fails_here < 10) $display("FAIL rand_ras cyc=%0d empty=%b full=%b ovf=%b unf=%b exp_count=%0d ovf=%b unf=%b",
                                      n, ras_empty, ras_full, ras_ovf, ras_unf, m_q.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    first = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    branch_target = '0; jump_target = '0; ret_addr = '0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_wrap();
    test_stall();
    test_branch_priority();
    test_ras_overflow();
    test_call_ret_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
